// File: rtl/instr_sequencer_if.sv
// Sequencer <-> program memory / execution unit signal bundle.
// master = sequencer side, slave = memory and execution unit side.
interface instr_sequencer_if;
    logic        run_en;
    logic        clear_err;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic [3:0]  done_in;

    logic        fetch_req;
    logic [15:0] ir_out;
    logic [3:0]  start;
    logic        busy;
    logic        halted;
    logic        err_illegal;
    logic        err_timeout;
    logic [15:0] retired_cnt;

    modport master (
        input  run_en, clear_err, instr_in, instr_valid, done_in,
        output fetch_req, ir_out, start, busy, halted,
               err_illegal, err_timeout, retired_cnt
    );

    modport slave (
        output run_en, clear_err, instr_in, instr_valid, done_in,
        input  fetch_req, ir_out, start, busy, halted,
               err_illegal, err_timeout, retired_cnt
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch into IR, decode, grant one execution unit, retire; watchdog/illegal traps.
// Latency: accept at FETCH t -> start t+2 .. done, RETIRE one cycle later; NOP round trip 3 cycles.
// Backpressure: FETCH waits unbounded on instr_valid, EXEC waits on done_in (watchdog-bounded). Macro: SEQ_RETIRE_CNT_EN.
module instr_sequencer #(
    parameter int TIMEOUT = 32,
    parameter int TO_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.master  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_RETIRE = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      start_q, start_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            ill_q, ill_d;
    logic            to_q, to_d;
    logic            fetch_q, fetch_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;

    logic [3:0]      grant;
    logic            grant_vld;
    logic            exec_done;
    logic            wd_expired;

    // Opcode to unit grant; NOP, HALT and illegal opcodes grant nothing.
    always_comb begin
        grant     = 4'b0000;
        grant_vld = 1'b0;
        case (ir_q[15:12])
            4'h1, 4'h2: begin grant = 4'b0010; grant_vld = 1'b1; end
            4'h3, 4'h4: begin grant = 4'b0001; grant_vld = 1'b1; end
            4'h5:       begin grant = 4'b0100; grant_vld = 1'b1; end
            4'h6:       begin grant = 4'b1000; grant_vld = 1'b1; end
            default:    begin grant = 4'b0000; grant_vld = 1'b0; end
        endcase
    end

    // Only the granted unit's done counts; start_q is one-hot during EXEC.
    assign exec_done  = |(bus.done_in & start_q);
    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        start_d = start_q;
        wd_d    = wd_q;
        ill_d   = ill_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run_en) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_q[15:12] == 4'h0) begin
                    state_d = S_RETIRE;
                end else if (ir_q[15:12] == 4'hF) begin
                    state_d = S_HALT;
                end else if (grant_vld) begin
                    start_d = grant;
                    wd_d    = '0;
                    state_d = S_EXEC;
                end else begin
                    ill_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                wd_d = wd_q + TO_W'(1);
                if (exec_done) begin
                    start_d = 4'b0000;
                    state_d = S_RETIRE;
                end else if (wd_expired) begin
                    start_d = 4'b0000;
                    to_d    = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_RETIRE: begin
                state_d = bus.run_en ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERR: begin
                start_d = 4'b0000;
                if (bus.clear_err) begin
                    ill_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                start_d = 4'b0000;
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_comb begin
        fetch_d  = (state_d == S_FETCH);
        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXEC)  || (state_d == S_RETIRE);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            start_q  <= '0;
            wd_q     <= '0;
            ill_q    <= 1'b0;
            to_q     <= 1'b0;
            fetch_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            start_q  <= start_d;
            wd_q     <= wd_d;
            ill_q    <= ill_d;
            to_q     <= to_d;
            fetch_q  <= fetch_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_RETIRE) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.retired_cnt = cnt_q;
`else
    assign bus.retired_cnt = 16'h0000;
`endif

    assign bus.fetch_req   = fetch_q;
    assign bus.ir_out      = ir_q;
    assign bus.start       = start_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.err_illegal = ill_q;
    assign bus.err_timeout = to_q;

    a_start_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(start_q));
    a_start_exec:   assert property (@(posedge clk) disable iff (!rst)
                                     (start_q != 4'b0000) |-> (state_q == S_EXEC));

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised bench for instr_sequencer with a transaction-level timeline model.
module tb_instr_sequencer;
    localparam int TIMEOUT = 32;
`ifdef SEQ_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_sequencer_if bus();

    instr_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Expected outputs for the current cycle, set by the stimulus timeline.
    logic        e_en = 1'b0;
    logic        e_fr, e_bz, e_hl, e_ill, e_to;
    logic [15:0] e_ir, e_cnt;
    logic [3:0]  e_st;

    // Architectural model state.
    logic [15:0] m_ir, m_cnt;
    logic        m_ill, m_to;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (e_en) begin
            check("fetch_req",   16'(bus.fetch_req),   16'(e_fr));
            check("ir_out",      bus.ir_out,           e_ir);
            check("start",       16'(bus.start),       16'(e_st));
            check("busy",        16'(bus.busy),        16'(e_bz));
            check("halted",      16'(bus.halted),      16'(e_hl));
            check("err_illegal", 16'(bus.err_illegal), 16'(e_ill));
            check("err_timeout", 16'(bus.err_timeout), 16'(e_to));
            check("retired_cnt", bus.retired_cnt,      e_cnt);
        end
    end

    // Accept-to-first-start latency monitor.
    int         cyc = 0, acc_cyc = 0, lat = -1;
    logic [3:0] first_start = 4'b0000, prev_start = 4'b0000;
    always @(negedge clk) begin
        cyc++;
        if (bus.fetch_req && bus.instr_valid) acc_cyc = cyc;
        if (bus.start != 4'b0000 && prev_start == 4'b0000) begin
            lat         = cyc - acc_cyc;
            first_start = bus.start;
        end
        prev_start = bus.start;
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction
    function automatic logic [3:0] rn();
        return 4'($urandom);
    endfunction

    // -1 NOP, -2 HALT, -3 illegal, otherwise the granted unit index.
    function automatic int unit_of(input logic [3:0] op);
        case (op)
            4'h0:       return -1;
            4'h1, 4'h2: return 1;
            4'h3, 4'h4: return 0;
            4'h5:       return 2;
            4'h6:       return 3;
            4'hF:       return -2;
            default:    return -3;
        endcase
    endfunction

    task automatic zero_model();
        m_ir = '0; m_cnt = '0; m_ill = 1'b0; m_to = 1'b0;
        e_fr = 1'b0; e_bz = 1'b0; e_hl = 1'b0; e_ill = 1'b0; e_to = 1'b0;
        e_ir = '0; e_cnt = '0; e_st = '0;
        bus.run_en = 1'b0; bus.clear_err = 1'b0; bus.instr_in = '0;
        bus.instr_valid = 1'b0; bus.done_in = '0;
    endtask

    // One clock cycle: expected outputs for this cycle plus the inputs driven in it.
    task automatic step(input logic fr, input logic [3:0] st, input logic bz, input logic hl,
                        input logic ret, input logic re, input logic iv, input logic [15:0] ii,
                        input logic [3:0] dn, input logic ce);
        e_fr = fr; e_st = st; e_bz = bz; e_hl = hl;
        e_ir = m_ir; e_ill = m_ill; e_to = m_to; e_cnt = CNT_EN ? m_cnt : 16'h0000;
        e_en = 1'b1;
        bus.run_en = re; bus.instr_valid = iv; bus.instr_in = ii;
        bus.done_in = dn; bus.clear_err = ce;
        @(posedge clk); #1;
        if (ret) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic idle_go(input int n);
        repeat (n) step(0, 4'b0, 0, 0, 0, 1'b0, rb(), rw(), rn(), rb());
        step(0, 4'b0, 0, 0, 0, 1'b1, rb(), rw(), rn(), rb());
    endtask

    task automatic err_recover(input int n);
        repeat (n) step(0, 4'b0, 0, 0, 0, rb(), rb(), rw(), rn(), 1'b0);
        step(0, 4'b0, 0, 0, 0, rb(), rb(), rw(), rn(), 1'b1);
        m_ill = 1'b0;
        m_to  = 1'b0;
    endtask

    // Starts in a FETCH cycle. res: 0 next FETCH, 1 next IDLE, 2 ERR, 3 HALT.
    task automatic do_instr(input logic [15:0] instr, input int fw, input int k,
                            input logic run_after, output int res);
        int u, last;
        logic hit;
        logic [3:0] oh, dn;
        for (int i = 0; i < fw; i++) step(1, 4'b0, 1, 0, 0, rb(), 1'b0, rw(), rn(), rb());
        step(1, 4'b0, 1, 0, 0, rb(), 1'b1, instr, rn(), rb());
        m_ir = instr;
        step(0, 4'b0, 1, 0, 0, rb(), rb(), rw(), rn(), rb());
        u = unit_of(instr[15:12]);
        if (u == -2) begin res = 3; return; end
        if (u == -3) begin m_ill = 1'b1; res = 2; return; end
        if (u >= 0) begin
            oh   = 4'b0001 << u;
            hit  = (k >= 1 && k <= TIMEOUT);
            last = hit ? k : TIMEOUT;
            for (int j = 1; j <= last; j++) begin
                dn = rn() & ~oh;
                if (hit && j == last) dn = dn | oh;
                step(0, oh, 1, 0, 0, rb(), rb(), rw(), dn, rb());
            end
            if (!hit) begin m_to = 1'b1; res = 2; return; end
        end
        step(0, 4'b0, 1, 0, 1, run_after, rb(), rw(), rn(), rb());
        res = run_after ? 0 : 1;
    endtask

    // Asynchronous reset asserted mid-cycle, away from both clock edges.
    task automatic do_reset();
        #2;
        zero_model();
        rst = 1'b0;
        #1;
        check("rst_async_start", 16'(bus.start), 16'h0);
        check("rst_async_busy",  16'(bus.busy),  16'h0);
        check("rst_async_ir",    bus.ir_out,     16'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int res, op, r;
        zero_model();
        e_en = 1'b1;
        rst  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // ALUI, done after 8 EXEC cycles.
        idle_go(2);
        do_instr(16'h1085, 1, 8, 1'b1, res);
        check("alui_latency", 16'(lat), 16'd2);
        check("alui_start",   16'(first_start), 16'h0002);

        // ALU reg-reg; stray done bits on other units are randomised.
        do_instr(16'h3000, 0, 5, 1'b1, res);
        // Done on the very last watchdog cycle still wins.
        do_instr(16'h6000, 0, TIMEOUT, 1'b1, res);
        do_instr(16'h4abc, 2, 1, 1'b1, res);

        // LOAD with no done: watchdog trap.
        do_instr(16'h5000, 0, 0, 1'b1, res);
        check("to_flag_lit",  16'(bus.err_timeout), 16'h1);
        check("to_start_lit", 16'(bus.start),       16'h0);
        err_recover(3);
        check("to_cleared_lit", 16'(bus.err_timeout), 16'h0);

        // Illegal opcode, then HALT.
        idle_go(1);
        do_instr(16'h9000, 0, 0, 1'b1, res);
        check("ill_flag_lit", 16'(bus.err_illegal), 16'h1);
        err_recover(2);
        idle_go(0);
        do_instr(16'hF000, 0, 0, 1'b1, res);
        check("halt_lit", 16'(bus.halted), 16'h1);
        repeat (5) step(0, 4'b0, 0, 1, 0, rb(), rb(), rw(), rn(), rb());
        check("halt_nofetch_lit", 16'(bus.fetch_req), 16'h0);
        do_reset();

        // Three back-to-back NOPs.
        idle_go(0);
        do_instr(16'h0000, 0, 0, 1'b1, res);
        do_instr(16'h0123, 0, 0, 1'b1, res);
        do_instr(16'h0fff, 0, 0, 1'b0, res);
        check("nop_cnt_lit", bus.retired_cnt, CNT_EN ? 16'd3 : 16'd0);

        // Reset while 0x2041 executes.
        idle_go(0);
        step(1, 4'b0, 1, 0, 0, 1'b1, 1'b1, 16'h2041, 4'b0, 1'b0);
        m_ir = 16'h2041;
        step(0, 4'b0, 1, 0, 0, 1'b1, 1'b0, rw(), 4'b0, 1'b0);
        repeat (3) step(0, 4'b0010, 1, 0, 0, 1'b1, 1'b0, rw(), 4'b1101, 1'b0);
        do_reset();

        // Randomised instruction stream.
        idle_go(1);
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       op = r;
            else if (r == 7) op = $urandom_range(7, 14);
            else if (r == 8) op = 15;
            else             op = $urandom_range(1, 6);
            do_instr({4'(op), 12'($urandom)}, $urandom_range(0, 3),
                     $urandom_range(1, TIMEOUT + 4), ($urandom_range(0, 3) != 0), res);
            case (res)
                1: idle_go($urandom_range(0, 3));
                2: begin err_recover($urandom_range(0, 3)); idle_go($urandom_range(0, 2)); end
                3: begin
                    repeat (3) step(0, 4'b0, 0, 1, 0, rb(), rb(), rw(), rn(), rb());
                    do_reset();
                    idle_go($urandom_range(0, 2));
                end
                default: ;
            endcase
        end

        e_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Top-level instruction sequencer for the microcontroller.
- Fetches a 16-bit instruction from program memory and holds it in an instruction register.
- Decodes opcode [15:12] and grants the shared bus/ALU datapath to exactly one execution FSM (ALU, ALUI, LOAD, STORE) via a one-hot start vector.
- Waits for that unit's done, retires, and fetches the next instruction; provides watchdog and illegal-opcode trapping.

Parameters:
- TIMEOUT, 32, max EXEC cycles before watchdog trap (2..63)
- TO_W, 6, watchdog counter width; must hold TIMEOUT

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- run_en  in  1  level; allows leaving IDLE and continuing after RETIRE
- clear_err  in  1  pulse; ERR -> IDLE
- instr_in  in  16  instruction word from program memory
- instr_valid  in  1  instr_in valid this cycle; sampled only in FETCH
- done_in  in  4  per-unit done: [0]=ALU, [1]=ALUI, [2]=LOAD, [3]=STORE
- fetch_req  out  1  instruction request to memory
- ir_out  out  16  held instruction, fed to all units as fullBitNum
- start  out  4  one-hot unit grant, same bit order as done_in
- busy  out  1  high in FETCH, DECODE, EXEC, RETIRE
- halted  out  1  high in HALT
- err_illegal  out  1  sticky illegal-opcode flag
- err_timeout  out  1  sticky watchdog flag
- retired_cnt  out  16  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including ir_out, start, flags, retired_cnt and watchdog.
- States: IDLE, FETCH, DECODE, EXEC, RETIRE, HALT, ERR. All outputs are registered.
- IDLE: run_en=1 -> FETCH.
- FETCH:
  - fetch_req=1.
  - instr_valid=1 -> ir_out<=instr_in, DECODE.
  - Otherwise remain; wait is unbounded.
- DECODE (exactly 1 cycle), opcode=ir_out[15:12]:
  - 0x0 NOP -> RETIRE.
  - 0x1, 0x2 (ALUI) -> unit 1.
  - 0x3, 0x4 (ALU reg-reg) -> unit 0.
  - 0x5 -> unit 2.
  - 0x6 -> unit 3.
  - 0xF -> HALT.
  - Any other opcode -> err_illegal<=1, ERR.
  - Selected unit: start[u]<=1, watchdog<=0, EXEC.
- EXEC:
  - start[u] held high and ir_out held stable for the whole state.
  - Watchdog increments each cycle.
  - done_in[u]=1 -> start<=0, RETIRE.
  - done bits of non-granted units are ignored.
  - Watchdog==TIMEOUT-1 with no done -> start<=0, err_timeout<=1, ERR.
  - If done and timeout coincide, done wins.
- RETIRE (1 cycle):
  - run_en=1 -> FETCH; else IDLE.
- HALT: stays until reset; halted=1.
- ERR: all starts 0; clear_err=1 -> flags cleared, IDLE.
- Latency: instruction accepted at FETCH cycle t, unit done at EXEC cycle k (first EXEC cycle = 1) -> start high t+2..t+1+k, RETIRE at t+2+k, next fetch_req at t+3+k. NOP: FETCH->DECODE->RETIRE->FETCH = 3 cycles.
- start is never multi-hot and never asserted outside EXEC.
- run_en dropping mid-instruction does not abort it; the sequencer stops at RETIRE.
- Reset mid-EXEC drops start immediately (async).

Optional Feature:
- Macro: SEQ_RETIRE_CNT_EN.
- Defined: retired_cnt increments by 1 on every RETIRE cycle (NOPs included), wraps 0xFFFF->0x0000; cleared only by reset.
- Undefined: no counter logic; retired_cnt tied to 0.

Test Plan:
- Reset then run_en=1, instr_valid with 0x1085 (ALUI) -> start=4'b0010 from cycle 2 after accept. done_in[1] after 8 EXEC cycles -> RETIRE, then fetch_req=1 next cycle; err flags 0.
- 0x3000 with done_in[1] pulsed at EXEC cycle 2 and done_in[0] at cycle 5 -> stray done ignored; retires at cycle 5 via unit 0.
- 0x5000, no done for 32 EXEC cycles -> start drops, err_timeout=1, state ERR. clear_err pulse -> IDLE, flags 0.
- 0x9000 -> err_illegal=1 after DECODE, start never asserted. Then 0xF000 after clear_err -> halted=1, fetch_req stays 0 thereafter.
- 3 consecutive NOPs -> fetch_req every 3rd cycle; with SEQ_RETIRE_CNT_EN retired_cnt=3, without it 0.
- rst low during EXEC of 0x2041 -> start, busy, ir_out =0 asynchronously; after release, state IDLE.
